// File: rtl/next_line_prefetcher.sv
// Next-line instruction prefetcher with a one-entry line buffer.
// Define PF_PAGE_BOUNDARY_EN to suppress prefetches that cross a 4 KiB page.
module next_line_prefetcher #(
    parameter int LINE_OFFSET_BITS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  icache_addr_i,
    input  logic         arbiter_inst_resp_i,
    output logic         arbiter_pf_read_o,
    output logic [31:0]  arbiter_pf_address_o,
    input  logic [255:0] arbiter_pf_rdata_i,
    input  logic         arbiter_pf_resp_i,
    input  logic         lookup_valid_i,
    input  logic [31:0]  lookup_addr_i,
    output logic         buf_hit_o,
    output logic [255:0] buf_rdata_o,
    input  logic         buf_take_i
);

    localparam logic [31:0] LINE_BYTES = 32'd1 << LINE_OFFSET_BITS;
    localparam logic [31:0] LINE_MASK  = ~(LINE_BYTES - 32'd1);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e         state_q;
    logic           valid_q;
    logic [31:0]    tag_q;
    logic [255:0]   data_q;
    logic           pend_v_q;
    logic [31:0]    pend_q;
    logic           read_q;
    logic [31:0]    addr_q;

    logic           take;
    logic           trig;
    logic           drop_dup;
    logic           drop_page;
    logic           accept;
    logic [31:0]    src;
    logic [31:0]    tgt;

    assign buf_hit_o = lookup_valid_i & valid_q
                     & ((lookup_addr_i & LINE_MASK) == tag_q);
    assign buf_rdata_o = data_q;

    assign arbiter_pf_read_o    = read_q;
    assign arbiter_pf_address_o = addr_q;

    // An icache miss completion takes priority over a buffer take.
    assign take = buf_take_i & buf_hit_o;
    assign trig = arbiter_inst_resp_i | take;
    assign src  = arbiter_inst_resp_i ? (icache_addr_i & LINE_MASK) : tag_q;
    assign tgt  = src + LINE_BYTES;

    assign drop_dup = valid_q & ~take & (tgt == tag_q);

`ifdef PF_PAGE_BOUNDARY_EN
    assign drop_page = (tgt[31:12] != src[31:12]);
`else
    assign drop_page = 1'b0;
`endif

    assign accept = trig & ~drop_dup & ~drop_page;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            data_q   <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            read_q   <= 1'b0;
            addr_q   <= '0;
        end else begin
            if (take) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ISSUE;
                        read_q  <= 1'b1;
                        addr_q  <= tgt;
                    end
                end
                ISSUE: begin
                    if (read_q && arbiter_pf_resp_i) begin
                        // Fill beats a same-cycle take; read drops for one cycle.
                        valid_q <= 1'b1;
                        tag_q   <= addr_q;
                        data_q  <= arbiter_pf_rdata_i;
                        read_q  <= 1'b0;
                        if (accept) begin
                            addr_q   <= tgt;
                            pend_v_q <= 1'b0;
                        end else if (pend_v_q) begin
                            addr_q   <= pend_q;
                            pend_v_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        read_q <= 1'b1;
                        if (accept) begin
                            pend_q   <= tgt;
                            pend_v_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_next_line_prefetcher.sv
// Self-checking bench for next_line_prefetcher: directed scenarios
// followed by randomized traffic against a transaction-level model.
module tb_next_line_prefetcher;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  icache_addr = '0;
    logic         inst_resp = 1'b0;
    logic         pf_read;
    logic [31:0]  pf_addr;
    logic [255:0] pf_rdata = '0;
    logic         pf_resp = 1'b0;
    logic         lookup_valid = 1'b0;
    logic [31:0]  lookup_addr = '0;
    logic         hit;
    logic [255:0] rdata;
    logic         take = 1'b0;

    int checks = 0;
    int errors = 0;

`ifdef PF_PAGE_BOUNDARY_EN
    localparam logic [31:0] PEND_SRC = 32'h1FC0;
    localparam logic [31:0] PEND_REQ = 32'h1FE0;
    localparam logic [31:0] TAGB     = 32'h6020;
`else
    localparam logic [31:0] PEND_SRC = 32'h1FE0;
    localparam logic [31:0] PEND_REQ = 32'h2000;
    localparam logic [31:0] TAGB     = 32'h6000;
`endif

    always #5 clk = ~clk;

    next_line_prefetcher dut (
        .clk                  (clk),
        .rst                  (rst),
        .icache_addr_i        (icache_addr),
        .arbiter_inst_resp_i  (inst_resp),
        .arbiter_pf_read_o    (pf_read),
        .arbiter_pf_address_o (pf_addr),
        .arbiter_pf_rdata_i   (pf_rdata),
        .arbiter_pf_resp_i    (pf_resp),
        .lookup_valid_i       (lookup_valid),
        .lookup_addr_i        (lookup_addr),
        .buf_hit_o            (hit),
        .buf_rdata_o          (rdata),
        .buf_take_i           (take)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference arithmetic: line address and next line, modulo 2^32.
    function automatic logic [31:0] line_of(logic [31:0] a);
        longint x;
        x = longint'(a);
        return 32'(x - (x % 32));
    endfunction

    function automatic logic [31:0] next_of(logic [31:0] l);
        longint x;
        x = longint'(l) + 32;
        return 32'(x % 64'h1_0000_0000);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 3) return 32'hFFFFFFE0 + $urandom_range(0, 31);
        return 32'h1F80 + $urandom_range(0, 15) * 32 + $urandom_range(0, 31);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b exp 0", pf_read); end
        checks++; if (pf_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", pf_addr); end
        lookup_valid = 1'b1;
        lookup_addr = 32'h0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b exp 0", hit); end
        lookup_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL reset_release_read: got %b exp 0", pf_read); end
    endtask

    task automatic test_basic();
        logic [255:0] d;
        icache_addr = 32'h1044;
        inst_resp = 1'b1;
        tick();
        inst_resp = 1'b0;
        checks++; if (pf_read !== 1'b1) begin errors++; $display("FAIL basic_read: got %b exp 1", pf_read); end
        checks++; if (pf_addr !== 32'h1060) begin errors++; $display("FAIL basic_addr: got %h exp 00001060", pf_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pf_read !== 1'b1 || pf_addr !== 32'h1060) begin
                errors++; $display("FAIL basic_hold: got %b/%h exp 1/00001060", pf_read, pf_addr);
            end
        end
        d = rnd256();
        pf_rdata = d;
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b exp 0", pf_read); end
        lookup_valid = 1'b1;
        lookup_addr = 32'h107C;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b exp 1", hit); end
        checks++; if (rdata !== d) begin errors++; $display("FAIL basic_data: got %h exp %h", rdata, d); end
        lookup_addr = 32'h1080;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL basic_miss: got %b exp 0", hit); end
        lookup_valid = 1'b0;
    endtask

    task automatic test_take();
        lookup_valid = 1'b1;
        lookup_addr = 32'h1060;
        take = 1'b1;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL take_hit: got %b exp 1", hit); end
        tick();
        take = 1'b0;
        checks++; if (pf_read !== 1'b1 || pf_addr !== 32'h1080) begin
            errors++; $display("FAIL take_req: got %b/%h exp 1/00001080", pf_read, pf_addr);
        end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL take_clear: got %b exp 0", hit); end
        lookup_valid = 1'b0;
        pf_rdata = rnd256();
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL take_done: got %b exp 0", pf_read); end
    endtask

    task automatic test_pending();
        logic [255:0] d3;
        logic [255:0] d4;
        icache_addr = PEND_SRC;
        inst_resp = 1'b1;
        tick();
        checks++; if (pf_read !== 1'b1 || pf_addr !== PEND_REQ) begin
            errors++; $display("FAIL pend_first: got %b/%h exp 1/%h", pf_read, pf_addr, PEND_REQ);
        end
        icache_addr = 32'h3000;
        tick();
        icache_addr = 32'h4000;
        tick();
        inst_resp = 1'b0;
        checks++; if (pf_read !== 1'b1 || pf_addr !== PEND_REQ) begin
            errors++; $display("FAIL pend_hold: got %b/%h exp 1/%h", pf_read, pf_addr, PEND_REQ);
        end
        d3 = rnd256();
        pf_rdata = d3;
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL pend_gap: got %b exp 0", pf_read); end
        tick();
        checks++; if (pf_read !== 1'b1 || pf_addr !== 32'h4020) begin
            errors++; $display("FAIL pend_second: got %b/%h exp 1/00004020", pf_read, pf_addr);
        end
        d4 = rnd256();
        pf_rdata = d4;
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL pend_single: got %b exp 0", pf_read); end
            tick();
        end
        lookup_valid = 1'b1;
        lookup_addr = 32'h4020;
        #1;
        checks++; if (hit !== 1'b1 || rdata !== d4) begin
            errors++; $display("FAIL pend_data: got %b/%h exp 1/%h", hit, rdata, d4);
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_page();
        icache_addr = 32'h1FE4;
        inst_resp = 1'b1;
        tick();
        inst_resp = 1'b0;
`ifdef PF_PAGE_BOUNDARY_EN
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL page_block: got %b exp 0", pf_read); end
        icache_addr = 32'hFFFFFFE0;
        inst_resp = 1'b1;
        tick();
        inst_resp = 1'b0;
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL page_wrap_block: got %b exp 0", pf_read); end
`else
        checks++; if (pf_read !== 1'b1 || pf_addr !== 32'h2000) begin
            errors++; $display("FAIL page_cross: got %b/%h exp 1/00002000", pf_read, pf_addr);
        end
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
        icache_addr = 32'hFFFFFFE0;
        inst_resp = 1'b1;
        tick();
        inst_resp = 1'b0;
        checks++; if (pf_read !== 1'b1 || pf_addr !== 32'h0) begin
            errors++; $display("FAIL page_wrap: got %b/%h exp 1/00000000", pf_read, pf_addr);
        end
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
`endif
    endtask

    task automatic test_simul();
        icache_addr = TAGB - 32'd32;
        inst_resp = 1'b1;
        tick();
        inst_resp = 1'b0;
        checks++; if (pf_read !== 1'b1 || pf_addr !== TAGB) begin
            errors++; $display("FAIL simul_fill_req: got %b/%h exp 1/%h", pf_read, pf_addr, TAGB);
        end
        pf_rdata = rnd256();
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
        icache_addr = 32'h5000;
        inst_resp = 1'b1;
        lookup_valid = 1'b1;
        lookup_addr = TAGB;
        take = 1'b1;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL simul_hit: got %b exp 1", hit); end
        tick();
        inst_resp = 1'b0;
        take = 1'b0;
        checks++; if (pf_read !== 1'b1 || pf_addr !== 32'h5020) begin
            errors++; $display("FAIL simul_req: got %b/%h exp 1/00005020", pf_read, pf_addr);
        end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL simul_clear: got %b exp 0", hit); end
        lookup_valid = 1'b0;
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
        tick();
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL simul_no_b: got %b exp 0", pf_read); end
    endtask

    task automatic test_reset_issue();
        icache_addr = 32'h7000;
        inst_resp = 1'b1;
        tick();
        inst_resp = 1'b0;
        checks++; if (pf_read !== 1'b1 || pf_addr !== 32'h7020) begin
            errors++; $display("FAIL rsti_req: got %b/%h exp 1/00007020", pf_read, pf_addr);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (pf_read !== 1'b0 || pf_addr !== 32'h0) begin
            errors++; $display("FAIL rsti_drop: got %b/%h exp 0/00000000", pf_read, pf_addr);
        end
        pf_rdata = rnd256();
        pf_resp = 1'b1;
        tick();
        pf_resp = 1'b0;
        checks++; if (pf_read !== 1'b0) begin errors++; $display("FAIL rsti_ignore: got %b exp 0", pf_read); end
        lookup_valid = 1'b1;
        lookup_addr = 32'h7020;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rsti_hit_line: got %b exp 0", hit); end
        lookup_addr = 32'h0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rsti_hit_zero: got %b exp 0", hit); end
        lookup_valid = 1'b0;
    endtask

    task automatic test_random();
        // Model: buffered line, one outstanding request, newest wanted line.
        logic         m_valid = 1'b0;
        logic [31:0]  m_tag = '0;
        logic [255:0] m_data = '0;
        logic         m_busy = 1'b0;
        logic         m_req = 1'b0;
        logic [31:0]  m_addr = '0;
        logic         m_want_v = 1'b0;
        logic [31:0]  m_want = '0;
        logic         e_hit;
        logic         e_take;
        logic         have;
        logic [31:0]  src;
        logic [31:0]  tgt;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            checks++; if (pf_read !== m_req) begin
                errors++; $display("FAIL rnd_read c=%0d: got %b exp %b", c, pf_read, m_req);
            end
            if (m_req) begin
                checks++; if (pf_addr !== m_addr) begin
                    errors++; $display("FAIL rnd_addr c=%0d: got %h exp %h", c, pf_addr, m_addr);
                end
            end
            icache_addr = rnd_addr();
            inst_resp = ($urandom_range(0, 99) < 20);
            lookup_valid = ($urandom_range(0, 99) < 60);
            lookup_addr = ($urandom_range(0, 1) == 0) ? m_tag + $urandom_range(0, 31) : rnd_addr();
            take = ($urandom_range(0, 1) == 1);
            pf_resp = ($urandom_range(0, 99) < (m_req ? 35 : 5));
            pf_rdata = rnd256();
            #1;
            e_hit = lookup_valid && m_valid && (line_of(lookup_addr) == m_tag);
            checks++; if (hit !== e_hit) begin
                errors++; $display("FAIL rnd_hit c=%0d: got %b exp %b", c, hit, e_hit);
            end
            if (e_hit) begin
                checks++; if (rdata !== m_data) begin
                    errors++; $display("FAIL rnd_data c=%0d: got %h exp %h", c, rdata, m_data);
                end
            end
            e_take = take && e_hit;
            have = 1'b0;
            src = '0;
            if (inst_resp) begin
                have = 1'b1;
                src = line_of(icache_addr);
            end else if (e_take) begin
                have = 1'b1;
                src = m_tag;
            end
            tgt = next_of(src);
            if (have && m_valid && !e_take && tgt == m_tag) have = 1'b0;
`ifdef PF_PAGE_BOUNDARY_EN
            if (have && (tgt / 4096) != (src / 4096)) have = 1'b0;
`endif
            if (e_take) m_valid = 1'b0;
            if (!m_busy) begin
                if (have) begin
                    m_busy = 1'b1;
                    m_req = 1'b1;
                    m_addr = tgt;
                end
            end else if (m_req && pf_resp) begin
                m_valid = 1'b1;
                m_tag = m_addr;
                m_data = pf_rdata;
                m_req = 1'b0;
                if (have) begin
                    m_addr = tgt;
                    m_want_v = 1'b0;
                end else if (m_want_v) begin
                    m_addr = m_want;
                    m_want_v = 1'b0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_req = 1'b1;
                if (have) begin
                    m_want = tgt;
                    m_want_v = 1'b1;
                end
            end
            tick();
        end
        inst_resp = 1'b0;
        pf_resp = 1'b0;
        lookup_valid = 1'b0;
        take = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_take();
        test_pending();
        test_page();
        test_simul();
        test_reset_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_line_prefetcher.md
NEXT_LINE_PREFETCHER -- requirements
Module: next_line_prefetcher

Interface
REQ-001 Parameter LINE_OFFSET_BITS, default 5: byte-offset width of a cache line (32-byte lines); line address = {addr[31:LINE_OFFSET_BITS], zeros}.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; one clock, reset synchronous and active-low (rst low at posedge clk resets).
REQ-004 icache_addr_i  input  32  address of the icache miss currently presented to the memory arbiter.
REQ-005 arbiter_inst_resp_i  input  1  arbiter completed the icache miss at icache_addr_i (1-cycle pulse).
REQ-006 arbiter_pf_read_o  output  1  prefetch read request to the arbiter prefetch port.
REQ-007 arbiter_pf_address_o  output  32  line-aligned prefetch address.
REQ-008 arbiter_pf_rdata_i  input  256  prefetched line data, valid with arbiter_pf_resp_i.
REQ-009 arbiter_pf_resp_i  input  1  prefetch read completed (1-cycle pulse).
REQ-010 lookup_valid_i  input  1  icache probes the prefetch buffer this cycle.
REQ-011 lookup_addr_i  input  32  probe address (any byte offset).
REQ-012 buf_hit_o  output  1  probe hits the buffered line, combinational, same cycle.
REQ-013 buf_rdata_o  output  256  buffered line data; meaningful only when buf_hit_o is high.
REQ-014 buf_take_i  input  1  icache consumes the hit line this cycle; ignored unless buf_hit_o is high.

Function
REQ-015 One-entry buffer: valid bit, line tag (32-bit line address), 256-bit data.
REQ-016 buf_hit_o SHALL equal lookup_valid_i & valid & (line(lookup_addr_i) == tag).
REQ-017 Trigger A: arbiter_inst_resp_i high -> target = line(icache_addr_i) + 2^LINE_OFFSET_BITS.
REQ-018 Trigger B: buf_take_i & buf_hit_o -> target = tag + 2^LINE_OFFSET_BITS.
REQ-019 Both triggers in the same cycle: A wins, B's target is dropped.
REQ-020 Target addition is modulo 2^32: 0xFFFFFFE0 + 32 = 0x00000000.
REQ-021 A target equal to the tag of a valid entry not being taken that cycle SHALL be discarded (no redundant fetch).
REQ-022 FSM states IDLE and ISSUE; IDLE -> ISSUE on an accepted target the cycle after the trigger, latching the target into arbiter_pf_address_o.
REQ-023 In ISSUE, arbiter_pf_read_o SHALL be held high and arbiter_pf_address_o stable until arbiter_pf_resp_i.
REQ-024 An accepted target arriving in ISSUE SHALL be stored in a one-deep pending register; a newer target overwrites it.
REQ-025 On arbiter_pf_resp_i in ISSUE: tag <= arbiter_pf_address_o, data <= arbiter_pf_rdata_i, valid <= 1; next state ISSUE with the pending address (pending cleared) if pending is valid, else IDLE.
REQ-026 arbiter_pf_read_o SHALL drop for at least one cycle between consecutive requests (IDLE passes or resp cycle deasserts).
REQ-027 Take with hit SHALL clear valid at the clock edge; fill and take in the same cycle: the fill wins (valid = 1, new data).
REQ-028 arbiter_pf_resp_i in IDLE SHALL be ignored.
REQ-029 Prefetch latency: arbiter_pf_read_o rises exactly 1 cycle after the trigger when the FSM is in IDLE.

Reset
REQ-030 With rst low: state IDLE, valid 0, pending 0, arbiter_pf_read_o 0, arbiter_pf_address_o 0x00000000, tag 0, data 0; buf_hit_o therefore 0.
REQ-031 Reset asserted in ISSUE SHALL drop arbiter_pf_read_o at that edge; a subsequent arbiter_pf_resp_i is ignored (REQ-028).

Configuration
REQ-032 Macro PF_PAGE_BOUNDARY_EN: when defined, a target whose bits [31:12] differ from the source line's bits [31:12] SHALL be discarded (no 4 KiB page crossing).
REQ-033 Without PF_PAGE_BOUNDARY_EN, page-crossing targets are prefetched, including the 0xFFFFFFE0 -> 0x00000000 wrap.

Verification
REQ-034 Pulse arbiter_inst_resp_i with icache_addr_i=0x00001044 -> next cycle arbiter_pf_read_o=1, arbiter_pf_address_o=0x00001060; held until resp; then lookup 0x0000107C hits with the returned data.
REQ-035 Buffer valid with tag 0x00001060, take with hit -> valid cleared, prefetch of 0x00001080 issued next cycle.
REQ-036 In ISSUE for 0x2000, triggers for 0x3000 then 0x4000 (source lines) -> after resp, a single request for 0x4020; 0x3020 is never requested.
REQ-037 icache_addr_i=0x00001FE4: with PF_PAGE_BOUNDARY_EN no request; without it a request to 0x00002000; icache_addr_i=0xFFFFFFE0 without the macro -> request to 0x00000000.
REQ-038 Assert rst low mid-ISSUE, then pulse arbiter_pf_resp_i -> arbiter_pf_read_o=0 after the edge, valid stays 0, buf_hit_o=0 for any probe.
REQ-039 Simultaneous arbiter_inst_resp_i (0x5000) and take-hit of tag 0x6000 -> request 0x5020 only; valid cleared.
